// File: rtl/decoder_mon_pkg.sv
// Shared types and helpers for the decoder line monitor.
// Holds the FSM state encoding, parameter defaults and the saturating increment.
package decoder_mon_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int LINES_DEF = 4;
  localparam int CNT_W_DEF = 8;

  // Returns value+1, but holds at max_value once it has been reached.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? max_value : value + 32'd1;
  endfunction

endpackage

// File: rtl/onehot_check.sv
// Combinational one-hot classifier for a decoder output word.
// Reports whether exactly one bit is set and, if so, its position.
module onehot_check #(
  parameter int LINES = 4,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic [LINES-1:0] word,
  output logic             is_onehot,
  output logic [IDX_W-1:0] idx
);

  localparam int OW = $clog2(LINES + 1);

  logic [OW-1:0] ones;

  always_comb begin
    ones = '0;
    idx  = '0;
    for (int i = 0; i < LINES; i++) begin
      if (word[i]) begin
        ones = ones + OW'(1);
        idx  = IDX_W'(i);
      end
    end
    is_onehot = (ones == OW'(1));
  end

endmodule

// File: rtl/decoder_line_counter.sv
// Per-line saturating hit counters for one-hot decoder outputs, with illegal-code
// tracking and a one-counter-per-cycle clear sweep.
module decoder_line_counter
  import decoder_mon_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [LINES-1:0] in_lines,
  output logic             in_ready,
  input  logic             clear,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] err_count,
  output logic [LINES-1:0] last_err_code,
  output logic             sat_any,
  output logic             clearing
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] sweep_idx_reg;
  logic [CNT_W-1:0] cnt_reg [LINES];

  logic             is_onehot;
  logic [IDX_W-1:0] hit_idx;
  logic [CNT_W-1:0] hit_next;
  logic [CNT_W-1:0] err_next;
  logic             accept;

  onehot_check #(
    .LINES (LINES),
    .IDX_W (IDX_W)
  ) u_onehot_check (
    .word      (in_lines),
    .is_onehot (is_onehot),
    .idx       (hit_idx)
  );

  // Ready is a function of state and clear only, so a pending clear always wins.
  assign in_ready = (state_reg == IDLE) && !clear;
  assign clearing = (state_reg == CLEAR);
  assign accept   = in_valid && in_ready;
  assign hit_next = CNT_W'(sat_inc(32'(cnt_reg[hit_idx]), 32'(CNT_MAX)));
  assign err_next = CNT_W'(sat_inc(32'(err_count), 32'(CNT_MAX)));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (clear) state_next = CLEAR;
      CLEAR:   if (sweep_idx_reg == LAST_IDX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sweep_idx_reg <= '0;
      err_count     <= '0;
      last_err_code <= '0;
      sat_any       <= 1'b0;
      rd_count      <= '0;
      for (int i = 0; i < LINES; i++) cnt_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      rd_count  <= (int'(rd_idx) < LINES) ? cnt_reg[rd_idx] : '0;

      if (state_reg == CLEAR) begin
        // Sticky status is dropped on the first sweep step, alongside counter 0.
        cnt_reg[sweep_idx_reg] <= '0;
        sweep_idx_reg <= (sweep_idx_reg == LAST_IDX) ? '0 : sweep_idx_reg + 1'b1;
        if (sweep_idx_reg == '0) begin
          err_count     <= '0;
          last_err_code <= '0;
          sat_any       <= 1'b0;
        end
      end else if (accept) begin
        if (is_onehot) begin
          cnt_reg[hit_idx] <= hit_next;
          if (hit_next == CNT_MAX) sat_any <= 1'b1;
        end else begin
          err_count     <= err_next;
          last_err_code <= in_lines;
          if (err_next == CNT_MAX) sat_any <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_decoder_line_counter.sv
// Random and directed stimulus against a queue-free behavioural model of the
// line monitor; every cycle compares handshake, readback and status outputs.
module tb_decoder_line_counter;

  localparam int LINES = 4;
  localparam int CNT_W = 8;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [LINES-1:0] in_lines = '0;
  logic             in_ready;
  logic             clear = 1'b0;
  logic [1:0]       rd_idx = '0;
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] err_count;
  logic [LINES-1:0] last_err_code;
  logic             sat_any;
  logic             clearing;

  int checks = 0;
  int errors = 0;

  // Behavioural model: counts per line, error state, remaining sweep cycles.
  int         m_cnt [LINES];
  int         m_err;
  logic [3:0] m_last;
  bit         m_sat;
  int         m_clear_left;

  decoder_line_counter #(
    .LINES (LINES),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_lines      (in_lines),
    .in_ready      (in_ready),
    .clear         (clear),
    .rd_idx        (rd_idx),
    .rd_count      (rd_count),
    .err_count     (err_count),
    .last_err_code (last_err_code),
    .sat_any       (sat_any),
    .clearing      (clearing)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_cnt[i] = 0;
    m_err = 0;
    m_last = '0;
    m_sat = 1'b0;
    m_clear_left = 0;
  endtask

  // One clock cycle: drive, check combinational handshake, advance model, check registers.
  task automatic step(input logic v, input logic [3:0] l, input logic c,
                      input logic [1:0] r, input logic rs);
    int exp_rd;
    int pos;
    int idx;
    in_valid = v;
    in_lines = l;
    clear    = c;
    rd_idx   = r;
    rst      = rs;
    #1;
    check("in_ready", 32'(in_ready), 32'(m_clear_left == 0 && !c));
    check("clearing", 32'(clearing), 32'(m_clear_left != 0));
    exp_rd = m_cnt[r];
    @(posedge clk);
    if (rs) begin
      model_reset();
      exp_rd = 0;
    end else if (m_clear_left > 0) begin
      pos = LINES - m_clear_left;
      if (pos == 0) begin
        m_err = 0;
        m_last = '0;
        m_sat = 1'b0;
      end
      m_cnt[pos] = 0;
      m_clear_left--;
    end else if (c) begin
      m_clear_left = LINES;
    end else if (v) begin
      if ($countones(l) == 1) begin
        idx = $clog2(l);
        if (m_cnt[idx] < MAXV) m_cnt[idx]++;
        if (m_cnt[idx] == MAXV) m_sat = 1'b1;
      end else begin
        if (m_err < MAXV) m_err++;
        if (m_err == MAXV) m_sat = 1'b1;
        m_last = l;
      end
    end
    #1;
    check("rd_count", 32'(rd_count), 32'(exp_rd));
    check("err_count", 32'(err_count), 32'(m_err));
    check("last_err_code", 32'(last_err_code), 32'(m_last));
    check("sat_any", 32'(sat_any), 32'(m_sat));
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 4'b0000, 1'b0, 2'd0, 1'b1);

    // Legal words then readback of every line.
    step(1'b1, 4'b0001, 1'b0, 2'd0, 1'b0);
    step(1'b1, 4'b0010, 1'b0, 2'd0, 1'b0);
    step(1'b1, 4'b0010, 1'b0, 2'd0, 1'b0);
    step(1'b1, 4'b1000, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0000, 1'b0, 2'(i), 1'b0);
    step(1'b0, 4'b0000, 1'b0, 2'd1, 1'b0);
    check("plan_line1", 32'(rd_count), 32'd2);
    $display("phase legal: err_count=%0d", err_count);

    // Illegal words.
    step(1'b1, 4'b0000, 1'b0, 2'd1, 1'b0);
    step(1'b1, 4'b0110, 1'b0, 2'd1, 1'b0);
    check("plan_last_err", 32'(last_err_code), 32'h6);
    $display("phase illegal: err_count=%0d last=%b", err_count, last_err_code);

    // Saturation of line 2.
    for (int i = 0; i < 260; i++) step(1'b1, 4'b0100, 1'b0, 2'd2, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 2'd2, 1'b0);
    check("plan_sat_cnt", 32'(rd_count), 32'd255);
    $display("phase saturate: rd_count=%0d sat_any=%0b", rd_count, sat_any);

    // Clear collides with a held word; the word is accepted only after the sweep.
    for (int i = 0; i < 6; i++) step(1'b1, 4'b0001, (i == 0), 2'd0, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
    check("plan_reaccept", 32'(rd_count), 32'd1);
    $display("phase clear: rd_count0=%0d sat_any=%0b", rd_count, sat_any);

    // Reset during the second cycle of a sweep.
    step(1'b0, 4'b0000, 1'b1, 2'd0, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 2'd0, 1'b1);
    step(1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
    $display("phase reset mid-sweep: clearing=%0b in_ready=%0b", clearing, in_ready);

    // Non-valid cycles with toggling data.
    for (int i = 0; i < 10; i++) step(1'b0, 4'($urandom), 1'b0, 2'(i), 1'b0);

    // Randomized traffic including rare clears and resets.
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3)),
           ($urandom_range(0, 40) == 0),
           2'($urandom),
           ($urandom_range(0, 400) == 0));
    $display("phase random: done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
